// File: rtl/reg_file_scanner.sv
// Read-side sequencer for reg_file: on start, dumps every register as one valid/ready word, in index order.
// Each pair costs 3 cycles (capture + two words) with out_ready high; a stalled word holds data/idx/last stable.
module reg_file_scanner #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rs1,
  output logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] rv1,
  input  logic [DATA_W-1:0] rv2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAP    = 2'd1,
    SEND_A = 2'd2,
    SEND_B = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] buf_b, buf_b_nxt;
  logic              busy_nxt, done_nxt;
  logic [ADDR_W-1:0] rs1_nxt, rs2_nxt;
  logic              out_valid_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic [ADDR_W-1:0] out_idx_nxt;
  logic              out_last_nxt;

  logic hs;
  logic pair_last;

  assign hs        = out_valid & out_ready;
  assign pair_last = (rs2 == LAST_IDX);

  // State and every output live in this one register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      buf_b     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rs1       <= '0;
      rs2       <= ADDR_W'(1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      buf_b     <= buf_b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      rs1       <= rs1_nxt;
      rs2       <= rs2_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_idx   <= out_idx_nxt;
      out_last  <= out_last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CAP;
      CAP:     state_nxt = SEND_A;
      SEND_A:  if (hs) state_nxt = SEND_B;
      SEND_B:  if (hs) state_nxt = pair_last ? IDLE : CAP;
      default: state_nxt = IDLE;
    endcase
  end

  // Both rs addresses were set a full cycle before CAP, so rv1/rv2 are settled snapshots.
  always_comb begin
    buf_b_nxt     = buf_b;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    rs1_nxt       = rs1;
    rs2_nxt       = rs2;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_idx_nxt   = out_idx;
    out_last_nxt  = out_last;
    case (state)
      IDLE: begin
        if (start) begin
          rs1_nxt  = '0;
          rs2_nxt  = ADDR_W'(1);
          busy_nxt = 1'b1;
        end
      end
      CAP: begin
        buf_b_nxt     = rv2;
        out_data_nxt  = rv1;
        out_idx_nxt   = rs1;
        out_valid_nxt = 1'b1;
        out_last_nxt  = 1'b0;
      end
      SEND_A: begin
        if (hs) begin
          out_data_nxt = buf_b;
          out_idx_nxt  = rs2;
          out_last_nxt = pair_last;
        end
      end
      SEND_B: begin
        if (hs) begin
          out_valid_nxt = 1'b0;
          if (pair_last) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end else begin
            rs1_nxt = rs1 + STEP;
            rs2_nxt = rs2 + STEP;
          end
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_file_scanner.sv
// Scoreboard bench for reg_file_scanner: a 32-register build plus a 4-register build fed from a modelled reg_file.
module tb_reg_file_scanner;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, out_ready;
  logic          busy, done, out_valid, out_last;
  logic [AW-1:0] rs1, rs2, out_idx;
  logic [DW-1:0] rv1, rv2, out_data;

  logic          start_b, out_ready_b;
  logic          busy_b, done_b, out_valid_b, out_last_b;
  logic [AW-1:0] rs1_b, rs2_b, out_idx_b;
  logic [DW-1:0] rv1_b, rv2_b, out_data_b;

  logic [DW-1:0] regs [32];

  assign rv1   = regs[rs1];
  assign rv2   = regs[rs2];
  assign rv1_b = regs[rs1_b];
  assign rv2_b = regs[rs2_b];
  assign out_ready_b = 1'b1;

  reg_file_scanner #(.NREGS(32), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rs1(rs1), .rs2(rs2), .rv1(rv1), .rv2(rv2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  reg_file_scanner #(.NREGS(4), .ADDR_W(AW), .DATA_W(DW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rs1(rs1_b), .rs2(rs2_b), .rv1(rv1_b), .rv2(rv2_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_idx(out_idx_b), .out_last(out_last_b)
  );

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t qa[$];
  word_t qb[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    stalls = 0;
  bit    rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] preload(input int i);
    return (i == 0) ? '0 : (32'hA500_0000 + 32'(i));
  endfunction

  task automatic push_a(input int cnt, input bit patch, input int pidx, input logic [DW-1:0] pval);
    for (int i = 0; i < cnt; i++) begin
      word_t w;
      w.idx  = AW'(i);
      w.data = (patch && i == pidx) ? pval : preload(i);
      w.last = (i == 31);
      qa.push_back(w);
    end
  endtask

  // out_ready driver: either tied high or a pseudo-random ~50% toggle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
  end

  // Monitor for the 32-register scanner.
  word_t held;
  bit    stall_prev = 1'b0;
  bit    done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_held", 64'(out_valid), 64'(1));
        chk("stall_data_held", 64'(out_data), 64'(held.data));
        chk("stall_idx_held", 64'(out_idx), 64'(held.idx));
        chk("stall_last_held", 64'(out_last), 64'(held.last));
      end
      stall_prev = out_valid && !out_ready;
      if (stall_prev) stalls++;
      held.idx  = out_idx;
      held.data = out_data;
      held.last = out_last;
      if (out_valid && out_ready) begin
        if (qa.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got idx %0d data 0x%0h, required no word", out_idx, out_data);
        end else begin
          word_t w;
          w = qa.pop_front();
          chk("word_idx", 64'(out_idx), 64'(w.idx));
          chk("word_data", 64'(out_data), 64'(w.data));
          chk("word_last", 64'(out_last), 64'(w.last));
        end
      end
      if (done) begin
        chk("done_single_cycle", 64'(done_prev), 64'(0));
        if (!done_prev) done_cnt++;
      end
      done_prev = done;
    end
  end

  // Monitor for the 4-register scanner.
  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word_b: got idx %0d, required no word", out_idx_b);
      end else begin
        word_t w;
        w = qb.pop_front();
        chk("b_word_idx", 64'(out_idx_b), 64'(w.idx));
        chk("b_word_data", 64'(out_data_b), 64'(w.data));
        chk("b_word_last", 64'(out_last_b), 64'(w.last));
      end
    end
  end

  task automatic do_start(output int e0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string name, output int at);
    at = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got no done pulse, required one within 3000 cycles", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, dc, d0, prev_dc;
    bit found;
    rst = 1'b1;
    start = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = preload(i);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rs1", 64'(rs1), 64'(0));
    chk("rst_rs2", 64'(rs2), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_idx", 64'(out_idx), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_b_rs2", 64'(rs2_b), 64'(1));

    // Full scan, ready tied high: first word after E1, done after E48.
    d0 = done_cnt;
    push_a(32, 1'b0, 0, '0);
    do_start(e0);
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("no_valid_after_E0", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("first_valid_after_E1", 64'(out_valid), 64'(1));
    wait_done("full_scan_done", dc);
    chk("done_edge_offset", 64'(dc - e0), 64'(48));
    chk("busy_low_with_done", 64'(busy), 64'(0));
    @(negedge clk);
    chk("done_dropped", 64'(done), 64'(0));
    chk("full_scan_drained", 64'(qa.size()), 64'(0));
    chk("full_scan_one_done", 64'(done_cnt - d0), 64'(1));

    // Same scan under random backpressure.
    d0 = done_cnt;
    rnd_ready = 1'b1;
    push_a(32, 1'b0, 0, '0);
    do_start(e0);
    wait_done("stall_scan_done", dc);
    rnd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_scan_drained", 64'(qa.size()), 64'(0));
    chk("stall_scan_saw_stalls", 64'(stalls > 0), 64'(1));
    chk("stall_scan_one_done", 64'(done_cnt - d0), 64'(1));

    // Start mid-scan must be ignored, not queued.
    d0 = done_cnt;
    push_a(32, 1'b0, 0, '0);
    do_start(e0);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore_start_done", dc);
    repeat (10) @(negedge clk);
    chk("ignore_start_no_rescan", 64'(out_valid), 64'(0));
    chk("ignore_start_idle", 64'(busy), 64'(0));
    chk("ignore_start_one_done", 64'(done_cnt - d0), 64'(1));
    chk("ignore_start_drained", 64'(qa.size()), 64'(0));

    // Reset right after idx 9 handshakes, then a clean rescan.
    d0 = done_cnt;
    push_a(10, 1'b0, 0, '0);
    do_start(e0);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_idx == AW'(9)) found = 1'b1;
    end
    chk("reset_saw_idx9", 64'(found), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    repeat (6) @(negedge clk);
    chk("reset_no_done", 64'(done_cnt - d0), 64'(0));
    chk("reset_no_more_words", 64'(qa.size()), 64'(0));
    push_a(32, 1'b0, 0, '0);
    do_start(e0);
    wait_done("rescan_done", dc);
    chk("rescan_done_edge", 64'(dc - e0), 64'(48));
    @(negedge clk);
    chk("rescan_drained", 64'(qa.size()), 64'(0));

    // Coherence: writes at E10 land after pair (2,3) capture, before pair (20,21).
    push_a(32, 1'b1, 20, 32'hDEAD_BEEF);
    do_start(e0);
    repeat (10) @(posedge clk);
    #1;
    regs[2]  = 32'h1234_5678;
    regs[20] = 32'hDEAD_BEEF;
    wait_done("coherence_done", dc);
    @(negedge clk);
    chk("coherence_drained", 64'(qa.size()), 64'(0));
    regs[2]  = preload(2);
    regs[20] = preload(20);

    // 4-register build with start held: back-to-back scans, 7 cycles apart.
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 4; i++) begin
        word_t w;
        w.idx  = AW'(i);
        w.data = preload(i);
        w.last = (i == 3);
        qb.push_back(w);
      end
    start_b = 1'b1;
    prev_dc = -1;
    for (int k = 0; k < 3; k++) begin
      dc = -1;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (done_b) begin
          dc = cyc;
          break;
        end
      end
      if (dc < 0) begin
        tests++;
        fails++;
        $display("FAIL b_done_timeout: got no done_b for scan %0d, required one", k);
        break;
      end
      chk("b_busy_low_with_done", 64'(busy_b), 64'(0));
      if (k > 0) chk("b_back_to_back_period", 64'(dc - prev_dc), 64'(7));
      prev_dc = dc;
      if (k == 2) begin
        start_b = 1'b0;
      end else begin
        @(negedge clk);
        chk("b_restart_same_edge", 64'(busy_b), 64'(1));
      end
    end
    start_b = 1'b0;
    repeat (10) @(negedge clk);
    chk("b_drained", 64'(qb.size()), 64'(0));
    chk("b_idle_after", 64'(busy_b), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_scanner.md
Name: reg_file_scanner

Overview:
- Automatic read-side master for `reg_file`. Replaces manual `rs1`/`rs2` driving with a sequenced dump of the whole register file.
- On a `start` pulse, walks register pairs (2k, 2k+1) through both read ports and captures `rv1`/`rv2`.
- Emits one word per register on a valid/ready stream, in index order, for consumption by debug/ILA or a UART/host bridge.
- Sits beside `reg_file`; shares its `clk`.

Parameters:
- NREGS, 32: registers scanned (even, 2..32); indices 0..NREGS-1.
- ADDR_W, 5: register index width.
- DATA_W, 32: register data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin scan; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final word handshakes.
- rs1  out  ADDR_W  read address to `reg_file` port 1 (even index).
- rs2  out  ADDR_W  read address to `reg_file` port 2 (odd index).
- rv1  in  DATA_W  `reg_file` read data 1 (combinational from rs1).
- rv2  in  DATA_W  `reg_file` read data 2 (combinational from rs2).
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  DATA_W  register value.
- out_idx  out  ADDR_W  register index of out_data.
- out_last  out  1  high with the word for index NREGS-1.

Behaviour:
- All outputs registered. Reset values: busy=0, done=0, rs1=0, rs2=1, out_valid=0, out_data=0, out_idx=0, out_last=0, state=IDLE, pair buffer=0.
- Handshake occurs on an edge where out_valid & out_ready.
- While out_valid=1 and out_ready=0, out_data, out_idx and out_last are held stable.
- out_valid never drops without a handshake, except on reset.
- FSM states:
  - IDLE: on start=1, set rs1<=0, rs2<=1, busy<=1, go to CAP.
  - CAP: capture buf_b<=rv2; set out_data<=rv1, out_idx<=rs1, out_valid<=1, out_last<=0; go to SEND_A. The rs address is stable for one full cycle before capture.
  - SEND_A: on handshake, set out_data<=buf_b, out_idx<=rs2, out_last<=(rs2==NREGS-1); go to SEND_B.
  - SEND_B: on handshake, set out_valid<=0.
    - If rs2==NREGS-1: busy<=0, done<=1, go to IDLE.
    - Otherwise: rs1<=rs1+2, rs2<=rs2+2, go to CAP.
- done is high for exactly one cycle.
- rs1/rs2 hold their last values in IDLE.
- Timing with out_ready tied high:
  - Start sampled at edge E0.
  - Pair k first word valid after edge E(1+3k); second word after E(2+3k).
  - NREGS=32: last handshake at E48; done high in the cycle after E48.
  - Throughput: 2 words per 3 cycles.
- start while busy=1 is ignored, not queued. start in the same cycle done is high starts a new scan.
- Coherence: each pair is a snapshot at its CAP cycle. Writes to `reg_file` during a scan affect only pairs not yet captured.
- Register x0 is passed through as read; `reg_file` returns 0, so the scanner makes no special case.
- rst mid-scan: state returns to IDLE on that edge, out_valid=0 the next cycle, no done pulse, no further words.
- Index arithmetic is ADDR_W bits. NREGS=32 ends at rs2=31 with no wrap past 31.

Test Plan:
- Preload reg_file r[i]=0xA5000000+i (r0=0), pulse start, out_ready=1 -> 32 words, out_idx 0..31, out_data=r[i], out_last only on idx 31, first valid 2 cycles after start, done pulse cycle after E48, busy low with done.
- Same preload, out_ready toggling pseudo-randomly (~50%) -> identical 32-word sequence; data/idx/last held stable on every stalled cycle; no word dropped or duplicated.
- Pulse start again at cycle 10 of an active scan -> ignored; exactly one 32-word sequence and one done pulse.
- Assert rst for one cycle after word idx 9 handshakes -> out_valid=0, busy=0 next cycle; no done; new start gives a full sequence from idx 0.
- During scan, write r[20]=0xDEADBEEF before pair (20,21) is captured and r[2]=0x12345678 after pair (2,3) is captured -> stream shows 0xDEADBEEF at idx 20 and the old r[2] value at idx 2.
- NREGS=4 build, start held high continuously -> back-to-back scans of 4 words each (idx 0..3, last on 3); each done pulse is followed by a new scan on the same edge.
